flash_loader: RTL and testbench

Main-clock sequencer that copies a block of words from the serial flash into on-chip RAM, e.g. bitstream-side boot data or a ROM image at power-up. It sits directly upstream of the flash serial controller, driving its enable, write, erase and address inputs. It consumes the controller's read data and word-finished strobe, then writes each word to a single-port RAM write interface. A start/busy/done handshake lets a CPU or reset sequencer trigger a load and wait for completion.

---
 rtl/flash_loader.sv | 150 +++++++++++++++
 tb/tb_flash_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_loader.sv
// Copies in_len flash words into RAM via the flash serial controller.
// Ports: start/busy/done/error handshake, flash controller drive and
// read-back, single-port RAM write. FLASH_LOADER_CHECKSUM_EN adds
// out_checksum, a running XOR of all words written.
module flash_loader #(
  parameter int WORD_BITS      = 8,
  parameter int ADDRESS_WORDS  = 2,
  parameter int MEM_ADDR_BITS  = 12,
  parameter int LEN_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                               in_clk,
  input  logic                               in_rst,
  input  logic                               in_start,
  input  logic [ADDRESS_WORDS*WORD_BITS-1:0] in_flash_addr,
  input  logic [MEM_ADDR_BITS-1:0]           in_mem_addr,
  input  logic [LEN_BITS-1:0]                in_len,
  output logic                               out_busy,
  output logic                               out_done,
  output logic                               out_error,
  output logic [LEN_BITS-1:0]                out_words_loaded,
  output logic                               out_flash_enable,
  output logic                               out_flash_write,
  output logic                               out_flash_erase,
  output logic [ADDRESS_WORDS*WORD_BITS-1:0] out_flash_addr,
  input  logic [WORD_BITS-1:0]               in_flash_data,
  input  logic                               in_flash_word_finished,
  output logic                               out_mem_write,
  output logic [MEM_ADDR_BITS-1:0]           out_mem_addr,
  output logic [WORD_BITS-1:0]               out_mem_data
`ifdef FLASH_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_BITS-1:0]               out_checksum
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, READ, RELEASE, DONE
  } state_t;

  state_t state_q, state_d;

  logic s1, s2, s3;
  logic rise;
  logic start_ok, word_hit, tmo_hit;
  logic [LEN_BITS-1:0]      len_q;
  logic [LEN_BITS-1:0]      words_q;
  logic [MEM_ADDR_BITS-1:0] base_q;
  logic [TW-1:0]            tmo_q;
  logic [RW-1:0]            rel_q;

  // word_finished is a slow level from the serial domain
  assign rise = s2 & ~s3;

  assign out_words_loaded = words_q;
  assign out_flash_write  = 1'b0;
  assign out_flash_erase  = 1'b0;
  assign out_busy         = (state_q == READ) | (state_q == RELEASE);
  assign out_done         = (state_q == DONE);
  assign out_flash_enable = (state_q == READ);

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    word_hit = 1'b0;
    tmo_hit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_start) begin
          start_ok = 1'b1;
          state_d  = (in_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (words_q == len_q) begin
          state_d = RELEASE;
        end else if (rise) begin
          word_hit = 1'b1;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (rel_q == RW'(RELEASE_CYCLES - 1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      len_q          <= '0;
      words_q        <= '0;
      base_q         <= '0;
      tmo_q          <= '0;
      rel_q          <= '0;
      out_error      <= 1'b0;
      out_flash_addr <= '0;
      out_mem_write  <= 1'b0;
      out_mem_addr   <= '0;
      out_mem_data   <= '0;
    end else begin
      s1            <= in_flash_word_finished;
      s2            <= s1;
      s3            <= s2;
      out_mem_write <= word_hit;
      rel_q         <= (state_q == RELEASE) ? rel_q + 1'b1 : '0;
      if (start_ok) begin
        len_q          <= in_len;
        base_q         <= in_mem_addr;
        out_flash_addr <= in_flash_addr;
        words_q        <= '0;
        out_error      <= 1'b0;
        tmo_q          <= '0;
      end
      if (word_hit) begin
        out_mem_data <= in_flash_data;
        out_mem_addr <= base_q + MEM_ADDR_BITS'(words_q);
        words_q      <= words_q + 1'b1;
        tmo_q        <= '0;
      end else if (state_q == READ) begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (tmo_hit) out_error <= 1'b1;
    end
  end

`ifdef FLASH_LOADER_CHECKSUM_EN
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst)       out_checksum <= '0;
    else if (start_ok) out_checksum <= '0;
    else if (word_hit) out_checksum <= out_checksum ^ in_flash_data;
  end
`endif

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader: normal load, zero length, timeout,
// RAM address wrap, reset mid-load and surplus flash words.
module tb_flash_loader;

  localparam int TMO = 64;
  localparam int REL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] f_addr = '0;
  logic [11:0] m_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, error;
  logic [15:0] words;
  logic        flash_enable, flash_write, flash_erase;
  logic [15:0] flash_addr;
  logic [7:0]  flash_data = '0;
  logic        word_fin = 1'b0;
  logic        mem_write;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int tests = 0;
  int fails = 0;

  int wa_q[$];
  int wd_q[$];
  int done_cnt = 0;
  int en_cnt = 0;
  int low_run = 0;

  flash_loader #(
    .TIMEOUT_CYCLES(TMO),
    .RELEASE_CYCLES(REL)
  ) dut (
    .in_clk                 (clk),
    .in_rst                 (rst_n),
    .in_start               (start),
    .in_flash_addr          (f_addr),
    .in_mem_addr            (m_addr),
    .in_len                 (len),
    .out_busy               (busy),
    .out_done               (done),
    .out_error              (error),
    .out_words_loaded       (words),
    .out_flash_enable       (flash_enable),
    .out_flash_write        (flash_write),
    .out_flash_erase        (flash_erase),
    .out_flash_addr         (flash_addr),
    .in_flash_data          (flash_data),
    .in_flash_word_finished (word_fin),
    .out_mem_write          (mem_write),
    .out_mem_addr           (mem_addr),
    .out_mem_data           (mem_data)
`ifdef FLASH_LOADER_CHECKSUM_EN
    ,
    .out_checksum           (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_write) begin
        wa_q.push_back(int'(mem_addr));
        wd_q.push_back(int'(mem_data));
      end
      if (done) done_cnt++;
      if (flash_enable) en_cnt++;
      if (busy && !flash_enable) low_run++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] fa,
                          input logic [11:0] ma,
                          input logic [15:0] n);
    f_addr = fa;
    m_addr = ma;
    len    = n;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    f_addr = 16'hdead;
    m_addr = 12'h555;
    len    = 16'd9;
  endtask

  task automatic send_word(input logic [7:0] d);
    flash_data = d;
    word_fin   = 1'b1;
    repeat (4) @(negedge clk);
    word_fin   = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(done_cnt != d0), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int d0, e0, l0, w0;
    logic [7:0] da [4];
    int         aa [4];

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    check("rst_en", flash_enable, 0);
    check("rst_mw", mem_write, 0);
    check("rst_words", words, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_mdata", mem_data, 0);
    check("rst_faddr", flash_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic load of four words
    da = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    d0 = done_cnt; w0 = wa_q.size(); l0 = low_run;
    do_start(16'h1234, 12'h010, 16'd4);
    check("a_busy", busy, 1);
    check("a_en", flash_enable, 1);
    check("a_faddr", flash_addr, 16'h1234);
    check("a_wr", flash_write, 0);
    check("a_er", flash_erase, 0);
    for (int i = 0; i < 4; i++) send_word(da[i]);
    wait_done(d0, "a_done");
    check("a_nwr", wa_q.size() - w0, 4);
    for (int i = 0; i < 4; i++) begin
      check("a_addr", wa_q[w0+i], 16 + i);
      check("a_data", wd_q[w0+i], int'(da[i]));
    end
    check("a_words", words, 4);
    check("a_ndone", done_cnt - d0, 1);
    check("a_err", error, 0);
    check("a_rel", low_run - l0, REL);
    check("a_busy_end", busy, 0);
`ifdef FLASH_LOADER_CHECKSUM_EN
    check("a_csum", checksum, 8'h66);
`endif

    // zero length
    d0 = done_cnt; e0 = en_cnt;
    do_start(16'h0000, 12'h000, 16'd0);
    check("z_done", done, 1);
    repeat (3) @(negedge clk);
    check("z_ndone", done_cnt - d0, 1);
    check("z_en", en_cnt - e0, 0);
    check("z_words", words, 0);

    // flash stops after two of five words
    d0 = done_cnt; w0 = wa_q.size();
    do_start(16'h0100, 12'h020, 16'd5);
    send_word(8'h12);
    send_word(8'h34);
    wait_done(d0, "t_done");
    check("t_err", error, 1);
    check("t_words", words, 2);
    check("t_nwr", wa_q.size() - w0, 2);
    check("t_ndone", done_cnt - d0, 1);

    // RAM address wrap; start also clears error
    aa = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    da = '{8'h01, 8'h02, 8'h04, 8'h08};
    d0 = done_cnt; w0 = wa_q.size();
    do_start(16'h0200, 12'hFFE, 16'd4);
    check("w_err_clr", error, 0);
    for (int i = 0; i < 4; i++) send_word(da[i]);
    wait_done(d0, "w_done");
    check("w_nwr", wa_q.size() - w0, 4);
    for (int i = 0; i < 4; i++) begin
      check("w_addr", wa_q[w0+i], aa[i]);
      check("w_data", wd_q[w0+i], int'(da[i]));
    end
`ifdef FLASH_LOADER_CHECKSUM_EN
    check("w_csum", checksum, 8'h0F);
`endif

    // reset after the third word
    d0 = done_cnt;
    do_start(16'hABCD, 12'h040, 16'd5);
    send_word(8'h55);
    send_word(8'h66);
    send_word(8'h77);
    check("r_pre_words", words, 3);
    rst_n = 1'b0;
    #1;
    check("r_en", flash_enable, 0);
    check("r_busy", busy, 0);
    check("r_words", words, 0);
    check("r_maddr", mem_addr, 0);
    check("r_mdata", mem_data, 0);
    check("r_faddr", flash_addr, 0);
`ifdef FLASH_LOADER_CHECKSUM_EN
    check("r_csum", checksum, 0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("r_nodone", done_cnt - d0, 0);
    da = '{8'h11, 8'h22, 8'h33, 8'h00};
    d0 = done_cnt; w0 = wa_q.size();
    do_start(16'h0300, 12'h100, 16'd3);
    for (int i = 0; i < 3; i++) send_word(da[i]);
    wait_done(d0, "r2_done");
    check("r2_nwr", wa_q.size() - w0, 3);
    for (int i = 0; i < 3; i++) begin
      check("r2_addr", wa_q[w0+i], 12'h100 + i);
      check("r2_data", wd_q[w0+i], int'(da[i]));
    end
    check("r2_words", words, 3);
    check("r2_err", error, 0);

    // surplus words beyond len
    d0 = done_cnt; w0 = wa_q.size(); l0 = low_run;
    do_start(16'h0400, 12'h200, 16'd2);
    send_word(8'hC1);
    send_word(8'hC2);
    send_word(8'hC3);
    send_word(8'hC4);
    wait_done(d0, "x_done");
    check("x_nwr", wa_q.size() - w0, 2);
    check("x_words", words, 2);
    check("x_rel", low_run - l0, REL);
    check("x_ndone", done_cnt - d0, 1);
    check("x_last", wd_q[wd_q.size()-1], 8'hC2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
